// File: rtl/seg_pkg.sv
// Shared display definitions: active-low 7-segment glyphs for hex 0-F,
// the blank pattern, the legacy 12-bit status codes and a glyph lookup helper.
package seg_pkg;

    // Segment order {dp,g,f,e,d,c,b,a}; a 0 lights the segment. dp is off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Index n holds the glyph for hex digit n (entry 15 is listed first).
    localparam logic [15:0][7:0] SEG_HEX = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
        8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

    // Status codes inherited from the fixed-width combinational encoder.
    localparam logic [11:0] STATUS_IDLE       = 12'h000;
    localparam logic [11:0] STATUS_CALIB_BUSY = 12'hCA1;
    localparam logic [11:0] STATUS_CALIB_FAIL = 12'hCAF;
    localparam logic [11:0] STATUS_CLS_BUSY   = 12'hC15;
    localparam logic [11:0] STATUS_UART_LOAD  = 12'h10A;

    // Conventional source slot assignment on the board (0 = highest priority).
    typedef enum logic [1:0] {
        SRC_CALIB_BUSY = 2'd0,
        SRC_CALIB_FAIL = 2'd1,
        SRC_CLS_BUSY   = 2'd2,
        SRC_UART_LOAD  = 2'd3
    } status_src_e;

    // Hex nibble to active-low glyph.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment decoder, shared by
// the display blocks on the board.
module seg7_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    // Glyph lookup
    always_comb begin
        seg = hex_to_seg(hex);
    end

endmodule

// File: rtl/seg_status_scan.sv
// Prioritised status arbiter with sticky error latches, driving a multiplexed
// common-anode 7-segment display. The frame snapshot is only updated at the
// start of digit 0 so a frame never mixes two codes.
// Optional build macro SEG_STATUS_BLINK_EN: blink the display while the shown
// source is held only by its sticky latch.
module seg_status_scan
    import seg_pkg::*;
#(
    parameter int                      NUM_DIGITS   = 3,
    parameter int                      NUM_SRC      = 4,
    parameter logic [NUM_SRC-1:0]      STICKY_MASK  = 4'b0010,
    parameter int                      SCAN_DIV     = 50000,
    parameter int                      BLINK_DIV    = 24,
    parameter logic [4*NUM_DIGITS-1:0] DEFAULT_CODE = STATUS_IDLE
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_SRC-1:0]                src_active,
    input  logic [NUM_SRC*4*NUM_DIGITS-1:0]   src_code,
    input  logic                              sticky_clr,
    output logic [7:0]                        seg_cathodes,
    output logic [NUM_DIGITS-1:0]             seg_anodes,
    output logic [$clog2(NUM_SRC+1)-1:0]      cur_src,
    output logic [NUM_SRC-1:0]                sticky_flags
);

    localparam int CW   = 4 * NUM_DIGITS;
    localparam int SW   = $clog2(NUM_SRC + 1);
    localparam int CNTW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [NUM_SRC-1:0]    sticky_r;
    logic [CW-1:0]         sticky_code_r [NUM_SRC];
    logic [NUM_SRC-1:0]    eff_s;
    logic [CW-1:0]         win_code_s;
    logic [SW-1:0]         win_idx_s;
    logic                  found_s;
    logic [CNTW-1:0]       scan_cnt_r;
    logic [IDXW-1:0]       digit_idx_r;
    logic [CW-1:0]         snap_r;
    logic [SW-1:0]         cur_src_r;
    logic [3:0]            nibble_s;
    logic [7:0]            glyph_s;
    logic [NUM_DIGITS-1:0] anode_s;
    logic [7:0]            cath_s;

    // Sticky latches: set has priority over clear; code captured on first set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_r <= {NUM_SRC{1'b0}};
            for (int i = 0; i < NUM_SRC; i++) begin
                sticky_code_r[i] <= {CW{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (STICKY_MASK[i] && src_active[i]) begin
                    sticky_r[i] <= 1'b1;
                    if (!sticky_r[i]) begin
                        sticky_code_r[i] <= src_code[i*CW +: CW];
                    end
                end else if (sticky_clr) begin
                    sticky_r[i] <= 1'b0;
                end
            end
        end
    end

    assign eff_s        = src_active | sticky_r;
    assign sticky_flags = sticky_r;

    // Priority arbitration: lowest active index wins, otherwise the default
    always_comb begin
        win_code_s = DEFAULT_CODE;
        win_idx_s  = SW'(NUM_SRC);
        found_s    = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found_s && eff_s[i]) begin
                found_s    = 1'b1;
                win_idx_s  = SW'(i);
                win_code_s = sticky_r[i] ? sticky_code_r[i] : src_code[i*CW +: CW];
            end else begin
                found_s    = found_s;
            end
        end
    end

    // Slot timer, digit index and frame snapshot taken as digit 0 begins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_r  <= {CNTW{1'b0}};
            digit_idx_r <= {IDXW{1'b0}};
            snap_r      <= DEFAULT_CODE;
            cur_src_r   <= SW'(NUM_SRC);
        end else if (scan_cnt_r == CNTW'(SCAN_DIV - 1)) begin
            scan_cnt_r <= {CNTW{1'b0}};
            if (digit_idx_r == IDXW'(NUM_DIGITS - 1)) begin
                digit_idx_r <= {IDXW{1'b0}};
                snap_r      <= win_code_s;
                cur_src_r   <= win_idx_s;
            end else begin
                digit_idx_r <= digit_idx_r + IDXW'(1);
            end
        end else begin
            scan_cnt_r <= scan_cnt_r + CNTW'(1);
        end
    end

    assign cur_src = cur_src_r;

    // Nibble of the snapshot belonging to the current digit
    always_comb begin
        nibble_s = snap_r[3:0];
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (digit_idx_r == IDXW'(d)) begin
                nibble_s = snap_r[d*4 +: 4];
            end else begin
                nibble_s = nibble_s;
            end
        end
    end

    seg7_hex_decode u_decode (
        .hex (nibble_s),
        .seg (glyph_s)
    );

`ifdef SEG_STATUS_BLINK_EN
    logic [BLINK_DIV-1:0] blink_cnt_r;
    logic [NUM_SRC:0]     sticky_ext_s;
    logic [NUM_SRC:0]     active_ext_s;
    logic                 latched_only_s;

    // Free-running blink phase counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r <= {BLINK_DIV{1'b0}};
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_DIV'(1);
        end
    end

    // Index NUM_SRC (the default slot) is never sticky
    assign sticky_ext_s   = {1'b0, STICKY_MASK};
    assign active_ext_s   = {1'b1, src_active};
    assign latched_only_s = sticky_ext_s[cur_src_r] & ~active_ext_s[cur_src_r];
`endif

    // Next pin values: one anode low per slot, blanked on the slot's first cycle
    always_comb begin
        cath_s = glyph_s;
        if (scan_cnt_r == {CNTW{1'b0}}) begin
            anode_s = {NUM_DIGITS{1'b1}};
        end else begin
            anode_s = ~(NUM_DIGITS'(1) << digit_idx_r);
        end
`ifdef SEG_STATUS_BLINK_EN
        if (latched_only_s && !blink_cnt_r[BLINK_DIV-1]) begin
            anode_s = {NUM_DIGITS{1'b1}};
        end else if (latched_only_s && (digit_idx_r == {IDXW{1'b0}})) begin
            cath_s[7] = 1'b0;
        end else begin
            cath_s = cath_s;
        end
`endif
    end

    // Registered display pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_anodes   <= {NUM_DIGITS{1'b1}};
            seg_cathodes <= SEG_BLANK;
        end else begin
            seg_anodes   <= anode_s;
            seg_cathodes <= cath_s;
        end
    end

endmodule

// File: doc/seg_status_scan.md
Name: seg_status_scan

Overview:
- Parametrised successor to the combinational status encoder.
- Arbitrates NUM_SRC prioritised status sources into an NUM_DIGITS-hex-digit code.
- Latches selected error sources as sticky.
- Time-multiplexes the result onto a common-anode 7-segment display. Sits between the system status signals (memory calibration, clear-screen, UART load) and the board display pins.

Parameters:
- NUM_DIGITS, 3: hex digits displayed; code width CW = 4*NUM_DIGITS.
- NUM_SRC, 4: number of status sources; index 0 has highest priority.
- STICKY_MASK, 4'b0010: bit i set makes source i sticky.
- SCAN_DIV, 50000: clk cycles per digit slot; must be ≥2.
- BLINK_DIV, 24: blink phase is bit BLINK_DIV-1 of a free-running BLINK_DIV-bit counter.
- DEFAULT_CODE, 12'h000: code shown when no source is active; width CW.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- src_active  in  NUM_SRC  source i requests display
- src_code  in  NUM_SRC*CW  code for source i at bits [i*CW +: CW]
- sticky_clr  in  1  one-cycle pulse clearing all sticky latches
- seg_cathodes  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
- seg_anodes  out  NUM_DIGITS  digit enables, active-low; bit 0 = rightmost digit
- cur_src  out  clog2(NUM_SRC+1)  index of the displayed source; NUM_SRC = default
- sticky_flags  out  NUM_SRC  current sticky latch state

Behaviour:
- Reset (async assert, sync deassert by upstream): seg_anodes all 1, seg_cathodes 8'hFF, cur_src = NUM_SRC, sticky_flags 0, scan counter 0, digit index 0, blink counter 0, frame snapshot = DEFAULT_CODE.
- Sticky latches:
  - For each i with STICKY_MASK[i]=1: set on clk edge when src_active[i]=1, cleared by sticky_clr.
  - Set wins when sticky_clr and src_active[i] are both 1 in the same cycle.
  - Effective active eff[i] = src_active[i] | sticky_flags[i].
  - Sticky code: the code captured on the cycle the latch first set, held while latched.
  - Non-sticky sources use live src_code.
- Arbitration (combinational): lowest i with eff[i]=1 wins; none → DEFAULT_CODE, index NUM_SRC.
- Scan counter:
  - Counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index increments modulo NUM_DIGITS.
- Frame snapshot:
  - When the digit index wraps NUM_DIGITS-1→0, the winner code and index register into the snapshot and cur_src.
  - A status change is therefore visible within at most one frame (NUM_DIGITS*SCAN_DIV cycles), never mid-frame (no tearing).
- Output registers:
  - seg_anodes drives exactly one 0, at bit = digit index.
  - seg_cathodes = hex-to-7seg of nibble [4*idx +: 4] of the snapshot; dp off (1).
  - One register stage from index change to pins.
  - Anodes blank (all 1) for the first cycle of every slot to prevent ghosting.
- Digit ordering: digit 0 shows the least-significant nibble.
- sticky_clr while the displayed source is sticky: the next frame re-arbitrates to the next active source.

Optional Feature:
- Macro: SEG_STATUS_BLINK_EN.
- Defined: when the snapshot source is sticky and its live src_active=0 (latched only), anodes are forced all 1 while the blink phase bit is 0. The display blinks at clk/2^BLINK_DIV, and dp is lit (0) on digit 0 during the on-phase.
- Undefined: sticky sources display steadily; the blink counter is not instantiated.

Decomposition:
- Shared package seg_pkg holds:
  - 7-segment encodings for hex 0–F (active-low).
  - SEG_BLANK = 8'hFF.
  - The legacy 12-bit status constants, so the top level builds DEFAULT_CODE and src_code from them.
- One sub-module: seg7_hex_decode (4-bit in, 8-bit active-low out, combinational), reused by other display blocks.

Test Plan (use SCAN_DIV=4, BLINK_DIV=4, defaults otherwise):
- Reset held then released, no sources active → after 1 frame, anodes cycle 110,101,011 (after blank cycle) with cathodes = encode(0); cur_src=4.
- src_active=4'b0100, code2=12'h2A5 → within 12 cycles the frame shows digits 5,A,2 on anodes 0,1,2; cur_src=2.
- Sources 1 and 3 simultaneously active → source 1 code shown. Deassert src_active[1] (sticky) → code1 persists; sticky_flags=4'b0010. Pulse sticky_clr → next frame shows source 3.
- sticky_clr coincident with src_active[1]=1 → sticky_flags[1] stays 1.
- src_code changed mid-frame → displayed nibbles unchanged until next digit-0 start.
- With SEG_STATUS_BLINK_EN and a latched-only sticky source → anodes all 1 for 8 cycles, active for 8 cycles, alternating. Without the macro → never blanked beyond slot-start cycles.
- rst_n asserted mid-slot → outputs go to reset values immediately, without waiting for a clk edge.
